// File: rtl/sha3_pkg.sv
// Shared SHA3 absorb definitions: mode encodings, rates, domain bytes, FSM state enum
// and the debug view of the absorb controller.
package sha3_pkg;

  localparam int WORD_BITS = 64;

  typedef enum logic [2:0] {
    MODE_SHAKE128 = 3'd0,
    MODE_SHAKE256 = 3'd1,
    MODE_SHA3_512 = 3'd2,
    MODE_SHA3_384 = 3'd3,
    MODE_SHA3_256 = 3'd4,
    MODE_SHA3_224 = 3'd5
  } mode_e;

  // Rate of each mode in 64-bit words (rate bytes / 8).
  localparam logic [4:0] RATE_SHAKE128 = 5'd21;
  localparam logic [4:0] RATE_SHAKE256 = 5'd17;
  localparam logic [4:0] RATE_SHA3_512 = 5'd9;
  localparam logic [4:0] RATE_SHA3_384 = 5'd13;
  localparam logic [4:0] RATE_SHA3_256 = 5'd17;
  localparam logic [4:0] RATE_SHA3_224 = 5'd18;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] FINAL_BIT    = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PAD   = 3'd2,
    ST_ZERO  = 3'd3,
    ST_START = 3'd4,
    ST_CLEAR = 3'd5,
    ST_WAIT  = 3'd6
  } state_e;

  typedef struct packed {
    state_e     state;
    logic [4:0] cnt;
    logic       last_seen;
    logic       pad_pending;
  } dbg_t;

  // Encodings 6 and 7 are reserved and fold onto SHA3-256.
  function automatic mode_e decode_mode(input logic [2:0] sel);
    if (sel > 3'd5) return MODE_SHA3_256;
    return mode_e'(sel);
  endfunction

  function automatic logic [4:0] rate_words(input mode_e m);
    logic [4:0] r;
    case (m)
      MODE_SHAKE128: r = RATE_SHAKE128;
      MODE_SHAKE256: r = RATE_SHAKE256;
      MODE_SHA3_512: r = RATE_SHA3_512;
      MODE_SHA3_384: r = RATE_SHA3_384;
      MODE_SHA3_224: r = RATE_SHA3_224;
      default:       r = RATE_SHA3_256;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] domain_byte(input mode_e m);
    if (m == MODE_SHAKE128 || m == MODE_SHAKE256) return DOMAIN_SHAKE;
    return DOMAIN_SHA3;
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational FIPS-202 multi-rate padding of one 64-bit word: keeps the valid
// bytes, places the domain byte after them and ORs the final bit into byte 7.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [3:0]           nbytes_i,
  input  logic [7:0]           domain_i,
  input  logic                 is_last_i,
  input  logic                 is_final_i,
  output logic [WORD_BITS-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < 8; k++) begin
      if (!is_last_i || (4'(k) < nbytes_i)) begin
        word_o[8*k +: 8] = word_i[8*k +: 8];
      end else if (4'(k) == nbytes_i) begin
        word_o[8*k +: 8] = domain_i;
      end
    end
    // is_final_i is only raised when the padding lives in the current block.
    if (is_final_i) begin
      word_o[63:56] = word_o[63:56] | FINAL_BIT;
    end
  end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// SHA3/SHAKE absorb sequencer: pads the message stream and drives the shift buffer
// and permutation start. Optional perf_blocks_o port under `SHA3_ABSORB_PERF_EN.
module sha3_absorb_ctrl
  import sha3_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mode_sel_i,
  input  logic              start_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [WORD_W-1:0] msg_data_i,
  input  logic              msg_last_i,
  input  logic [3:0]        msg_bytes_i,
  output logic [WORD_W-1:0] din64_o,
  output logic              hash_ready_o,
  output logic              flag_o,
  output logic              perm_start_o,
  input  logic              perm_done_i,
  output logic              busy_o,
  output logic              done_o,
`ifdef SHA3_ABSORB_PERF_EN
  output logic [31:0]       perf_blocks_o,
`endif
  output dbg_t              dbg_o
);

  // Handshake: a message word transfers on a rising edge where msg_valid_i and
  // msg_ready_o are both high; msg_ready_o depends only on state, never on valid,
  // and the source must hold data/last/bytes stable until the transfer.

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [4:0] cnt_q, cnt_d;
  logic       last_seen_q, last_seen_d;
  logic       pad_pending_q, pad_pending_d;
  logic       done_sticky_q, done_sticky_d;

  logic [4:0]        rate;
  logic [7:0]        domain;
  logic [4:0]        cnt_inc;
  logic              block_full;
  logic              at_final;
  logic [3:0]        last_bytes;
  logic              short_last;
  logic              shift;
  logic              perm_go;

  logic [WORD_W-1:0] pad_in;
  logic [3:0]        pad_nbytes;
  logic              pad_is_last;
  logic              pad_is_final;
  logic [WORD_W-1:0] pad_out;

  assign rate       = rate_words(mode_q);
  assign domain     = domain_byte(mode_q);
  assign cnt_inc    = cnt_q + 5'd1;
  assign block_full = (cnt_inc == rate);
  assign at_final   = (cnt_q == rate - 5'd1);
  assign last_bytes = (msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
  assign short_last = msg_last_i && (last_bytes != 4'd8);
  assign perm_go    = perm_done_i || done_sticky_q;

  // Padding source selection: message words in FILL, a domain-only word in PAD,
  // all-zero words in ZERO. The final bit is only applied once padding has begun.
  always_comb begin
    pad_in       = '0;
    pad_nbytes   = 4'd8;
    pad_is_last  = 1'b0;
    pad_is_final = 1'b0;
    case (state_q)
      ST_FILL: begin
        pad_in       = msg_data_i;
        pad_nbytes   = last_bytes;
        pad_is_last  = msg_last_i;
        pad_is_final = at_final && short_last;
      end
      ST_PAD: begin
        pad_nbytes   = 4'd0;
        pad_is_last  = 1'b1;
        pad_is_final = at_final;
      end
      ST_ZERO: begin
        pad_is_final = at_final;
      end
      default: ;
    endcase
  end

  sha3_pad_word u_pad (
    .word_i     (pad_in),
    .nbytes_i   (pad_nbytes),
    .domain_i   (domain),
    .is_last_i  (pad_is_last),
    .is_final_i (pad_is_final),
    .word_o     (pad_out)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    last_seen_d   = last_seen_q;
    pad_pending_d = pad_pending_q;
    done_sticky_d = done_sticky_q;
    msg_ready_o   = 1'b0;
    flag_o        = 1'b0;
    perm_start_o  = 1'b0;
    done_o        = 1'b0;
    shift         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d        = decode_mode(mode_sel_i);
          cnt_d         = 5'd0;
          last_seen_d   = 1'b0;
          pad_pending_d = 1'b0;
          done_sticky_d = 1'b0;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        msg_ready_o = 1'b1;
        if (msg_valid_i) begin
          shift = 1'b1;
          cnt_d = cnt_inc;
          if (msg_last_i) begin
            last_seen_d   = 1'b1;
            pad_pending_d = !short_last;
          end
          if (block_full)      state_d = ST_START;
          else if (msg_last_i) state_d = short_last ? ST_ZERO : ST_PAD;
        end
      end
      ST_PAD: begin
        shift         = 1'b1;
        cnt_d         = cnt_inc;
        pad_pending_d = 1'b0;
        state_d       = block_full ? ST_START : ST_ZERO;
      end
      ST_ZERO: begin
        shift   = 1'b1;
        cnt_d   = cnt_inc;
        state_d = block_full ? ST_START : ST_ZERO;
      end
      ST_START: begin
        perm_start_o = 1'b1;
        state_d      = ST_CLEAR;
      end
      ST_CLEAR: begin
        flag_o = 1'b1;
        cnt_d  = 5'd0;
        // A very fast permutation may finish while the buffer is still clearing.
        if (perm_done_i) done_sticky_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (perm_go) begin
          done_sticky_d = 1'b0;
          if (!last_seen_q) begin
            state_d = ST_FILL;
          end else if (pad_pending_q) begin
            state_d = ST_PAD;
          end else begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hash_ready_o = !shift;
  assign din64_o      = shift ? pad_out : '0;
  assign busy_o       = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_SHA3_256;
      cnt_q         <= 5'd0;
      last_seen_q   <= 1'b0;
      pad_pending_q <= 1'b0;
      done_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      last_seen_q   <= last_seen_d;
      pad_pending_q <= pad_pending_d;
      done_sticky_q <= done_sticky_d;
    end
  end

`ifdef SHA3_ABSORB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_blocks_o <= 32'd0;
    end else if (state_q == ST_START) begin
      perf_blocks_o <= perf_blocks_o + 32'd1;
    end
  end
`endif

  assign dbg_o.state       = state_q;
  assign dbg_o.cnt         = cnt_q;
  assign dbg_o.last_seen   = last_seen_q;
  assign dbg_o.pad_pending = pad_pending_q;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Self-checking bench for sha3_absorb_ctrl: a byte-level padding model fills an
// expected-word queue that is drained on every shift cycle of the DUT.
module tb_sha3_absorb_ctrl;
  import sha3_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  mode_sel_i;
  logic        start_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [63:0] msg_data_i;
  logic        msg_last_i;
  logic [3:0]  msg_bytes_i;
  logic [63:0] din64_o;
  logic        hash_ready_o;
  logic        flag_o;
  logic        perm_start_o;
  logic        perm_done_i;
  logic        busy_o;
  logic        done_o;
`ifdef SHA3_ABSORB_PERF_EN
  logic [31:0] perf_blocks_o;
`endif
  dbg_t        dbg_o;

  sha3_absorb_ctrl #(.WORD_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode_sel_i   (mode_sel_i),
    .start_i      (start_i),
    .msg_valid_i  (msg_valid_i),
    .msg_ready_o  (msg_ready_o),
    .msg_data_i   (msg_data_i),
    .msg_last_i   (msg_last_i),
    .msg_bytes_i  (msg_bytes_i),
    .din64_o      (din64_o),
    .hash_ready_o (hash_ready_o),
    .flag_o       (flag_o),
    .perm_start_o (perm_start_o),
    .perm_done_i  (perm_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
`ifdef SHA3_ABSORB_PERF_EN
    .perf_blocks_o(perf_blocks_o),
`endif
    .dbg_o        (dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int shifts_in_block = 0;
  int exp_rate = 0;
  int perm_lat = 1;
  bit prev_start = 1'b0;
  bit prev_shift = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tb_rate(input int m);
    case (m)
      0: return 21;
      1: return 17;
      2: return 9;
      3: return 13;
      5: return 18;
      default: return 17;
    endcase
  endfunction

  function automatic logic [7:0] tb_dom(input int m);
    return (m == 0 || m == 1) ? 8'h1F : 8'h06;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      shifts_in_block = 0;
      prev_start = 1'b0;
      prev_shift = 1'b0;
    end else begin
      if (dbg_o.state == ST_FILL) check_eq("cnt_track", 64'(dbg_o.cnt), 64'(shifts_in_block));
      if (prev_start) check_eq("flag_after_start", 64'(flag_o), 64'd1);
      if (!hash_ready_o) begin
        if (exp_q.size() == 0) check_eq("shift_with_empty_queue", 64'(exp_q.size()), 64'd1);
        else check_eq("din64", din64_o, exp_q.pop_front());
        shifts_in_block++;
      end
      if (perm_start_o) begin
        check_eq("words_per_block", 64'(shifts_in_block), 64'(exp_rate));
        check_eq("start_after_shift", 64'(prev_shift), 64'd1);
        start_cnt++;
        shifts_in_block = 0;
      end
      if (done_o) done_cnt++;
      prev_start = perm_start_o;
      prev_shift = !hash_ready_o;
    end
  end

  // Permutation model: done pulse perm_lat cycles after the CLEAR cycle begins
  // (perm_lat=0 lands the pulse inside CLEAR).
  initial begin
    perm_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (perm_start_o) begin
        @(posedge clk); #1;
        repeat (perm_lat) begin @(posedge clk); #1; end
        perm_done_i = 1'b1;
        @(posedge clk); #1;
        perm_done_i = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_msg(input int m);
    start_i = 1'b1;
    mode_sel_i = 3'(m);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("busy_after_start", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive_word(input logic [63:0] w, input bit last, input int nb,
                            input int gap, input bit poke_start);
    bit ok;
    msg_valid_i = 1'b0;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    msg_valid_i = 1'b1;
    msg_data_i  = w;
    msg_last_i  = last;
    msg_bytes_i = last ? 4'(nb) : 4'($urandom_range(0, 15));
    if (poke_start) begin
      start_i = 1'b1;
      mode_sel_i = 3'd2;
    end
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = msg_ready_o;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    if (!ok) check_eq("ready_timeout", 64'(ok), 64'd1);
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
  endtask

  task automatic send_msg(input int m, input int nwords, input int nb_in, input int gap,
                          input int lat, input bit poke);
    logic [63:0] words[$];
    logic [7:0]  bytes[$];
    logic [63:0] w;
    int nb, rb, nblk, starts0, dones0;
    nb = (nb_in > 8) ? 8 : nb_in;
    rb = tb_rate(m) * 8;
    for (int i = 0; i < nwords; i++) begin
      w = {$urandom, $urandom};
      words.push_back(w);
    end
    for (int i = 0; i < nwords; i++)
      for (int k = 0; k < 8; k++)
        if (i < nwords - 1 || k < nb) bytes.push_back(words[i][8*k +: 8]);
    bytes.push_back(tb_dom(m));
    while (bytes.size() % rb != 0) bytes.push_back(8'h00);
    bytes[bytes.size() - 1] = bytes[bytes.size() - 1] | 8'h80;
    nblk = bytes.size() / rb;
    for (int j = 0; j < bytes.size() / 8; j++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = bytes[8*j + k];
      exp_q.push_back(w);
    end
    perm_lat = lat;
    exp_rate = tb_rate(m);
    starts0  = start_cnt;
    dones0   = done_cnt;
    start_msg(m);
    for (int i = 0; i < nwords; i++)
      drive_word(words[i], i == nwords - 1, nb_in, gap, poke && i == 1);
    for (int t = 0; t < 3000 && done_cnt == dones0; t++) @(posedge clk);
    check_eq("done_pulses", 64'(done_cnt - dones0), 64'd1);
    check_eq("blocks", 64'(start_cnt - starts0), 64'(nblk));
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check_eq("idle_after_done", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_msg_ready"}, 64'(msg_ready_o), 64'd0);
    check_eq({tag, "_din64"}, din64_o, 64'd0);
    check_eq({tag, "_hash_ready"}, 64'(hash_ready_o), 64'd1);
    check_eq({tag, "_flag"}, 64'(flag_o), 64'd0);
    check_eq({tag, "_perm_start"}, 64'(perm_start_o), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_eq({tag, "_done"}, 64'(done_o), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_o.state), 64'(ST_IDLE));
    check_eq({tag, "_cnt"}, 64'(dbg_o.cnt), 64'd0);
  endtask

  task automatic reset_mid_fill();
    logic [63:0] w;
    perm_lat = 1;
    exp_rate = 17;
    start_msg(4);
    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom};
      exp_q.push_back(w);
      drive_word(w, 1'b0, 0, 1, 1'b0);
    end
    msg_valid_i = 1'b1;
    msg_data_i  = {$urandom, $urandom};
    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_fill_rst");
`ifdef SHA3_ABSORB_PERF_EN
    check_eq("perf_after_mid_reset", 64'(perf_blocks_o), 64'd0);
`endif
    exp_q.delete();
    msg_valid_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset       = 1'b1;
    mode_sel_i  = 3'd0;
    start_i     = 1'b0;
    msg_valid_i = 1'b0;
    msg_data_i  = '0;
    msg_last_i  = 1'b0;
    msg_bytes_i = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
`ifdef SHA3_ABSORB_PERF_EN
    check_eq("perf_after_reset", 64'(perf_blocks_o), 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    send_msg(0, 21, 8, 0, 2, 1'b0);          // SHAKE128, 168 bytes: two blocks
`ifdef SHA3_ABSORB_PERF_EN
    check_eq("perf_after_shake128", 64'(perf_blocks_o), 64'd2);
`endif
    send_msg(4, 1, 0, 0, 1, 1'b0);           // SHA3-256 empty message
    send_msg(5, 18, 7, 0, 3, 1'b0);          // SHA3-224, D|0x80 shares byte 7 of word 17
    send_msg(2, 20, 3, 3, $urandom_range(0, 4), 1'b0);  // SHA3-512 with valid gaps
    send_msg(7, 17, 8, 1, 0, 1'b1);          // mode 7 as SHA3-256, stray start, sticky done
    send_msg(3, 5, 12, 2, 1, 1'b0);          // SHA3-384, byte count above 8 clamps
    send_msg(1, $urandom_range(1, 40), $urandom_range(0, 8), 2, 2, 1'b0);  // SHAKE256
    reset_mid_fill();
    @(posedge clk); #1;
    send_msg(5, 3, 5, 1, 1, 1'b0);           // fresh message after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
